// File: rtl/dense_pkg.sv
// Shared state encoding and default field widths for the dense/activate schedulers.
package dense_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int unsigned ACT_TYPE_SIZE   = 4;
  localparam int unsigned DENSE_TYPE_SIZE = 4;
  localparam int unsigned COST_TYPE_SIZE  = 8;
  localparam int unsigned IDX_SIZE        = 32;

endpackage

// File: rtl/credit_counter.sv
// Downstream occupancy credit counter: starts full, -1 per issued beat, +1 per return.
// A return while already full is a protocol error; the count saturates instead of wrapping.
module credit_counter #(
  parameter int unsigned credits = 4,
  localparam int unsigned CNT_W = $clog2(credits + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             has_credit
);

  logic full;

  assign full       = (count == CNT_W'(credits));
  assign has_credit = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_W'(credits);
    end else begin
      unique case ({dec, inc})
        2'b10:   count <= count - CNT_W'(1);
        2'b01:   if (!full) count <= count + CNT_W'(1);
        default: ;
      endcase
    end
  end

  a_no_return_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(inc && full))
    else $error("credit_return while credit counter is full");

endmodule

// File: rtl/dense_activate_sched.sv
// Sequences network rows into the dense/activate pipeline, one registered beat per cycle.
// First beat 1 cycle after descriptor accept; beats stall while no downstream credit is left.
module dense_activate_sched
  import dense_pkg::*;
#(
  parameter int unsigned cost_type_size  = COST_TYPE_SIZE,
  parameter int unsigned dense_type_size = DENSE_TYPE_SIZE,
  parameter int unsigned act_type_size   = ACT_TYPE_SIZE,
  parameter int unsigned credits         = 4,
  parameter int unsigned idx_size        = IDX_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [idx_size-1:0]        cmd_num_layers,
  input  logic                       cmd_is_update,
  input  logic [cost_type_size-1:0]  cmd_cost_type,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [idx_size-1:0]        desc_rows,
  input  logic [act_type_size-1:0]   desc_act_type,
  input  logic [dense_type_size-1:0] desc_dense_type,
  input  logic                       desc_is_cost_layer,
  output logic                       issue_valid,
  output logic [act_type_size-1:0]   issue_act_type,
  output logic [dense_type_size-1:0] issue_dense_type,
  output logic [cost_type_size-1:0]  issue_cost_type,
  output logic [idx_size-1:0]        issue_w_layer_index,
  output logic [idx_size-1:0]        issue_w_row_index,
  output logic                       issue_is_update,
  output logic                       issue_is_cost_layer,
  output logic                       issue_backprop_cost,
  input  logic                       credit_return,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CNT_W = $clog2(credits + 1);

  sched_state_t        state, next_state;
  logic [idx_size-1:0] num_layers, rows;
  logic [CNT_W-1:0]    credit_count;
  logic                has_credit, credit_full, credit_next_ok;
  logic                last_layer, last_row, issue_next;

  credit_counter #(.credits(credits)) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec       (issue_valid),
    .inc       (credit_return),
    .count     (credit_count),
    .has_credit(has_credit)
  );

  // Compares against count-1 so full-range counts never need a wider counter.
  assign last_layer  = (issue_w_layer_index == num_layers - idx_size'(1));
  assign last_row    = (issue_w_row_index == rows - idx_size'(1));
  assign credit_full = (credit_count == CNT_W'(credits));

  // issue_valid is a flop, so look ahead at the counter value after this edge.
  assign credit_next_ok = credit_return || (credit_count > CNT_W'(1)) ||
                          (has_credit && !issue_valid);

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    desc_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) next_state = (cmd_num_layers == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          if (desc_rows != '0) next_state = ISSUE;
          else if (last_layer) next_state = DRAIN;
        end
      end
      ISSUE: begin
        if (issue_valid && last_row) next_state = last_layer ? DRAIN : LOAD;
      end
      DRAIN: begin
        if (credit_full) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    issue_next = (next_state == ISSUE) && credit_next_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      num_layers          <= '0;
      rows                <= '0;
      issue_valid         <= 1'b0;
      issue_act_type      <= '0;
      issue_dense_type    <= '0;
      issue_cost_type     <= '0;
      issue_w_layer_index <= '0;
      issue_w_row_index   <= '0;
      issue_is_update     <= 1'b0;
      issue_is_cost_layer <= 1'b0;
      issue_backprop_cost <= 1'b0;
    end else begin
      state       <= next_state;
      issue_valid <= issue_next;
      unique case (state)
        IDLE: if (cmd_valid) begin
          num_layers          <= cmd_num_layers;
          issue_is_update     <= cmd_is_update;
          issue_cost_type     <= cmd_cost_type;
          issue_w_layer_index <= '0;
          issue_w_row_index   <= '0;
        end
        LOAD: if (desc_valid) begin
          rows                <= desc_rows;
          issue_w_row_index   <= '0;
          issue_act_type      <= desc_act_type;
          issue_dense_type    <= desc_dense_type;
          issue_is_cost_layer <= desc_is_cost_layer;
          issue_backprop_cost <= issue_is_update && desc_is_cost_layer;
          if (desc_rows == '0) issue_w_layer_index <= issue_w_layer_index + idx_size'(1);
        end
        ISSUE: if (issue_valid) begin
          issue_w_row_index <= issue_w_row_index + idx_size'(1);
          if (last_row) issue_w_layer_index <= issue_w_layer_index + idx_size'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_activate_sched.sv
// Scoreboard bench: expected beats queued as descriptors are driven, compared as beats appear.
module tb_dense_activate_sched;

  localparam int CREDITS = 4;

  typedef struct packed {
    logic [31:0] layer;
    logic [31:0] row;
    logic [3:0]  act;
    logic [3:0]  dense;
    logic [7:0]  cost;
    logic        upd;
    logic        cl;
    logic        bp;
  } beat_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_is_update;
  logic [31:0] cmd_num_layers;
  logic [7:0]  cmd_cost_type;
  logic        desc_valid, desc_ready, desc_is_cost_layer;
  logic [31:0] desc_rows;
  logic [3:0]  desc_act_type, desc_dense_type;
  logic        issue_valid, issue_is_update, issue_is_cost_layer, issue_backprop_cost;
  logic [3:0]  issue_act_type, issue_dense_type;
  logic [7:0]  issue_cost_type;
  logic [31:0] issue_w_layer_index, issue_w_row_index;
  logic        credit_return, busy, done;

  dense_activate_sched #(.credits(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_layers(cmd_num_layers),
    .cmd_is_update(cmd_is_update), .cmd_cost_type(cmd_cost_type),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_rows(desc_rows),
    .desc_act_type(desc_act_type), .desc_dense_type(desc_dense_type),
    .desc_is_cost_layer(desc_is_cost_layer),
    .issue_valid(issue_valid), .issue_act_type(issue_act_type),
    .issue_dense_type(issue_dense_type), .issue_cost_type(issue_cost_type),
    .issue_w_layer_index(issue_w_layer_index), .issue_w_row_index(issue_w_row_index),
    .issue_is_update(issue_is_update), .issue_is_cost_layer(issue_is_cost_layer),
    .issue_backprop_cost(issue_backprop_cost),
    .credit_return(credit_return), .busy(busy), .done(done)
  );

  int    checks = 0, failures = 0;
  int    cyc = 0, beats = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0, drdy_seen = 0;
  int    last_ret_cyc = 0, acc_cyc = 0, man_req = 0;
  bit    auto_ret = 0;
  logic  cur_upd;
  logic [7:0] cur_cost;
  beat_t exp_q[$];
  int    bc[$];
  int    out_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Downstream model: holds one outstanding entry per beat, returns at most one per cycle.
  initial begin
    credit_return = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      credit_return = 0;
      if (!rst_n) begin
        out_q.delete();
      end else if (out_q.size() > 0 && (man_req > 0 || (auto_ret && out_q[0] + 2 <= cyc))) begin
        credit_return = 1;
        if (man_req > 0) man_req--;
        void'(out_q.pop_front());
        last_ret_cyc = cyc;
      end
    end
  end

  initial begin
    beat_t got;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) busy_cyc++;
        if (desc_ready) drdy_seen++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (issue_valid) begin
          beats++;
          bc.push_back(cyc);
          out_q.push_back(cyc);
          got = {issue_w_layer_index, issue_w_row_index, issue_act_type, issue_dense_type,
                 issue_cost_type, issue_is_update, issue_is_cost_layer, issue_backprop_cost};
          if (exp_q.size() == 0) chk("beat_extra", 128'(issue_valid), 128'(0));
          else chk("beat", 128'(got), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] n, input logic upd, input logic [7:0] cost);
    bit ok = 0;
    cur_upd = upd;
    cur_cost = cost;
    cmd_num_layers = n;
    cmd_is_update = upd;
    cmd_cost_type = cost;
    cmd_valid = 1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("cmd_handshake", 128'(cmd_ready), 128'(1));
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic send_desc(input int nrows, input logic [3:0] act, input logic [3:0] dense,
                           input logic cl, input int layer);
    bit ok = 0;
    beat_t e;
    for (int r = 0; r < nrows; r++) begin
      e.layer = 32'(layer); e.row = 32'(r); e.act = act; e.dense = dense;
      e.cost = cur_cost; e.upd = cur_upd; e.cl = cl; e.bp = cur_upd & cl;
      exp_q.push_back(e);
    end
    desc_rows = 32'(nrows);
    desc_act_type = act;
    desc_dense_type = dense;
    desc_is_cost_layer = cl;
    desc_valid = 1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = desc_ready;
    end
    if (!ok) chk("desc_handshake", 128'(desc_ready), 128'(1));
    acc_cyc = cyc;
    @(posedge clk);
    #1 desc_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) chk(tag, 128'(done), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beats = 0; done_cnt = 0; busy_cyc = 0; drdy_seen = 0;
    bc.delete();
  endtask

  int acc0;

  initial begin
    rst_n = 0;
    cmd_valid = 0; cmd_num_layers = 0; cmd_is_update = 0; cmd_cost_type = 0;
    desc_valid = 0; desc_rows = 0; desc_act_type = 0; desc_dense_type = 0;
    desc_is_cost_layer = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_desc_ready", 128'(desc_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_issue_valid", 128'(issue_valid), 128'(0));
    chk("rst_indices", 128'({issue_w_layer_index, issue_w_row_index}), 128'(0));
    @(posedge clk);
    #1;

    // Two layers {3,2}, returns 2 cycles after each beat.
    auto_ret = 1;
    clear_stats();
    send_cmd(2, 0, 8'h11);
    send_desc(3, 4'h1, 4'h2, 0, 0);
    acc0 = acc_cyc;
    send_desc(2, 4'h3, 4'h4, 0, 1);
    wait_done("t1_done");
    repeat (3) @(negedge clk);
    chk("t1_beats", 128'(bc.size()), 128'(5));
    if (bc.size() == 5) begin
      chk("t1_latency", 128'(bc[0]), 128'(acc0 + 1));
      chk("t1_gap", 128'(bc[3] - bc[2]), 128'(2));
      chk("t1_span", 128'(bc[4] - bc[0]), 128'(5));
    end
    chk("t1_done_cnt", 128'(done_cnt), 128'(1));
    chk("t1_done_after_ret", 128'(done_cyc), 128'(last_ret_cyc + 2));
    chk("t1_sb_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;

    // Credit starvation: 7 rows, no returns, then manual releases.
    auto_ret = 0;
    clear_stats();
    send_cmd(1, 0, 8'h22);
    send_desc(7, 4'h9, 4'hA, 0, 0);
    repeat (10) @(negedge clk);
    chk("t2_stall_beats", 128'(beats), 128'(CREDITS));
    chk("t2_stall_valid", 128'(issue_valid), 128'(0));
    man_req = 1;
    repeat (5) @(negedge clk);
    chk("t2_one_release", 128'(beats), 128'(CREDITS + 1));
    man_req = 2;
    repeat (6) @(negedge clk);
    chk("t2_two_release", 128'(beats), 128'(CREDITS + 3));
    chk("t2_busy_drain", 128'(busy), 128'(1));
    auto_ret = 1;
    @(posedge clk);
    #1;
    wait_done("t2_done");
    chk("t2_done_cnt", 128'(done_cnt), 128'(1));

    // Middle layer with zero rows is skipped.
    clear_stats();
    send_cmd(3, 0, 8'h33);
    send_desc(2, 4'h1, 4'h1, 0, 0);
    send_desc(0, 4'h2, 4'h2, 0, 1);
    send_desc(3, 4'h3, 4'h3, 0, 2);
    wait_done("t3_done");
    chk("t3_beats", 128'(beats), 128'(5));
    chk("t3_sb_empty", 128'(exp_q.size()), 128'(0));

    // Zero-layer pass.
    clear_stats();
    send_cmd(0, 0, 8'h44);
    wait_done("t4_done");
    repeat (3) @(negedge clk);
    chk("t4_busy_cycles", 128'(busy_cyc), 128'(2));
    chk("t4_desc_ready", 128'(drdy_seen), 128'(0));
    chk("t4_beats", 128'(beats), 128'(0));
    chk("t4_done_cnt", 128'(done_cnt), 128'(1));
    @(posedge clk);
    #1;

    // Backprop cost flag with and without update.
    send_cmd(2, 1, 8'h5A);
    send_desc(2, 4'h5, 4'h6, 0, 0);
    send_desc(3, 4'h7, 4'h8, 1, 1);
    wait_done("t5a_done");
    send_cmd(2, 0, 8'hC3);
    send_desc(2, 4'h5, 4'h6, 1, 0);
    send_desc(3, 4'h7, 4'h8, 1, 1);
    wait_done("t5b_done");
    chk("t5_sb_empty", 128'(exp_q.size()), 128'(0));

    // Reset during row 1 of 4.
    clear_stats();
    send_cmd(1, 0, 8'h66);
    send_desc(4, 4'hB, 4'hC, 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_valid", 128'(issue_valid), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_fields", 128'({issue_w_row_index, issue_act_type, issue_cost_type}), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 128'(done_cnt), 128'(0));
    @(posedge clk);
    #1;
    bc.delete();
    send_cmd(1, 0, 8'h77);
    send_desc(4, 4'hD, 4'hE, 0, 0);
    wait_done("t6_done");
    chk("t6_beats", 128'(bc.size()), 128'(4));
    if (bc.size() == 4) chk("t6_full_credit_span", 128'(bc[3] - bc[0]), 128'(3));
    chk("t6_done_cnt", 128'(done_cnt), 128'(1));
    chk("t6_sb_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
